// File: rtl/cordic_op_sequencer.sv
`timescale 1ns/1ps
// Purpose: maps one CORDIC command onto an external iterative datapath and returns the selected result words.
// Latency: LOAD 1 cycle after accept, ITER step cycles, 1 settle cycle, then result held in DONE.
// Backpressure: result held stable until res_ready; cmd_ready low (commands ignored) outside IDLE.
module cordic_op_sequencer #(
  parameter int             W      = 16,
  parameter int             ITER   = 16,
  parameter int             IDX_W  = 5,
  parameter logic [W-1:0]   KC_INV = 16'h26DD,
  parameter logic [W-1:0]   KH_INV = 16'h4D48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_func,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  output logic             dp_load,
  output logic [W-1:0]     dp_x0,
  output logic [W-1:0]     dp_y0,
  output logic [W-1:0]     dp_z0,
  output logic [1:0]       dp_coord,
  output logic             dp_vec,
  output logic             dp_step,
  output logic [IDX_W-1:0] dp_idx,
  input  logic [W-1:0]     dp_x,
  input  logic [W-1:0]     dp_y,
  input  logic [W-1:0]     dp_z,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       res_func,
  output logic [W-1:0]     res_p,
  output logic [W-1:0]     res_q,
  output logic             busy
);

  localparam int          CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [1:0]  C_LIN = 2'b00;
  localparam logic [1:0]  C_CIR = 2'b01;
  localparam logic [1:0]  C_HYP = 2'b10;
  // 1.0 in Q2.14
  localparam logic [W-1:0] ONE  = {2'b01, {(W-2){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             alive_q;
  logic [2:0]       func_q;
  logic [W-1:0]     a_q, b_q;
  logic [CNT_W-1:0] step_cnt;
  logic             cmd_fire;
  logic [2:0]       mode_nxt;
  logic [W-1:0]     ix, iy, iz;
  logic [W-1:0]     p_nxt, q_nxt;
  logic [IDX_W-1:0] k_ext, hyp_idx;

  // {coord, vec} for each function code
  function automatic logic [2:0] map_mode(input logic [2:0] f);
    logic [2:0] m;
    m = {C_LIN, 1'b0};
    case (f)
      3'd0: m = {C_LIN, 1'b0};
      3'd1: m = {C_LIN, 1'b1};
      3'd2: m = {C_CIR, 1'b0};
      3'd3: m = {C_CIR, 1'b1};
      3'd4: m = {C_HYP, 1'b0};
      3'd5: m = {C_HYP, 1'b0};
      3'd6: m = {C_HYP, 1'b1};
      3'd7: m = {C_CIR, 1'b1};
    endcase
    return m;
  endfunction

  assign cmd_fire = (state == S_IDLE) && alive_q && cmd_valid;
  assign mode_nxt = map_mode(cmd_func);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Keeps cmd_ready low while in reset and until the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive_q <= 1'b0;
    else        alive_q <= 1'b1;
  end

  // Capture the command and its coordinate/mode; held until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dp_coord <= C_LIN;
      dp_vec   <= 1'b0;
    end else if (cmd_fire) begin
      func_q   <= cmd_func;
      a_q      <= cmd_a;
      b_q      <= cmd_b;
      dp_coord <= mode_nxt[2:1];
      dp_vec   <= mode_nxt[0];
    end
  end

  // Step counter: counts micro-rotations while in RUN, parked at 0 otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              step_cnt <= '0;
    else if (state == S_RUN) step_cnt <= step_cnt + CNT_W'(1);
    else                     step_cnt <= '0;
  end

  // Register the selected result words when the datapath has settled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p    <= '0;
      res_q    <= '0;
      res_func <= '0;
    end else if (state == S_SETTLE) begin
      res_p    <= p_nxt;
      res_q    <= q_nxt;
      res_func <= func_q;
    end
  end

  // Initial vector for the captured function (one-operand codes ignore a)
  always_comb begin
    ix = '0;
    iy = '0;
    iz = '0;
    case (func_q)
      3'd0: begin ix = a_q;    iy = '0;  iz = b_q; end
      3'd1: begin ix = a_q;    iy = b_q; iz = '0;  end
      3'd2: begin ix = KC_INV; iy = '0;  iz = b_q; end
      3'd3: begin ix = ONE;    iy = b_q; iz = '0;  end
      3'd4: begin ix = KH_INV; iy = '0;  iz = b_q; end
      3'd5: begin ix = KH_INV; iy = '0;  iz = b_q; end
      3'd6: begin ix = ONE;    iy = b_q; iz = '0;  end
      3'd7: begin ix = a_q;    iy = b_q; iz = '0;  end
    endcase
  end

  // Result selection from the final datapath registers
  always_comb begin
    p_nxt = '0;
    q_nxt = '0;
    case (func_q)
      3'd0: p_nxt = dp_y;
      3'd1: p_nxt = dp_z;
      3'd2: begin p_nxt = dp_x; q_nxt = dp_y; end
      3'd3: p_nxt = dp_z;
      3'd4: begin p_nxt = dp_x; q_nxt = dp_y; end
      3'd5: p_nxt = dp_x + dp_y;
      3'd6: p_nxt = dp_z;
      3'd7: begin p_nxt = dp_z; q_nxt = dp_x; end
    endcase
  end

  // Hyperbolic schedule starts at 1 and repeats indices 4 and 13 for convergence
  always_comb begin
    k_ext   = IDX_W'(step_cnt);
    hyp_idx = k_ext + IDX_W'(1);
    if (k_ext >= IDX_W'(4))  hyp_idx = hyp_idx - IDX_W'(1);
    if (k_ext >= IDX_W'(14)) hyp_idx = hyp_idx - IDX_W'(1);
  end

  // Next-state and output decode
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    dp_load   = 1'b0;
    dp_x0     = '0;
    dp_y0     = '0;
    dp_z0     = '0;
    dp_step   = 1'b0;
    dp_idx    = '0;
    res_valid = 1'b0;
    case (state)
      S_IDLE: begin
        busy      = 1'b0;
        cmd_ready = alive_q;
        if (cmd_fire) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        dp_load   = 1'b1;
        dp_x0     = ix;
        dp_y0     = iy;
        dp_z0     = iz;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        dp_step = 1'b1;
        dp_idx  = (dp_coord == C_HYP) ? hyp_idx : k_ext;
        if (step_cnt == CNT_W'(ITER - 1)) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cordic_op_sequencer.sv
`timescale 1ns/1ps
// Purpose: directed bench for cordic_op_sequencer with a behavioural CORDIC datapath model.
// Latency: counts edges from accept to res_valid and logs the issued step indices.
// Backpressure: holds res_ready low with cmd_valid asserted to exercise stall and back-to-back accept.
module tb_cordic_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_func;
  logic [15:0] cmd_a, cmd_b;
  logic        dp_load;
  logic [15:0] dp_x0, dp_y0, dp_z0;
  logic [1:0]  dp_coord;
  logic        dp_vec;
  logic        dp_step;
  logic [4:0]  dp_idx;
  logic [15:0] dp_x, dp_y, dp_z;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  res_func;
  logic [15:0] res_p, res_q;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .dp_load(dp_load), .dp_x0(dp_x0), .dp_y0(dp_y0), .dp_z0(dp_z0),
    .dp_coord(dp_coord), .dp_vec(dp_vec), .dp_step(dp_step), .dp_idx(dp_idx),
    .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_func(res_func),
    .res_p(res_p), .res_q(res_q), .busy(busy)
  );

  // ---------------- behavioural datapath: 8 extra fraction bits internally ----------------
  longint atan_t [0:31];
  longint atanh_t[0:31];
  longint lin_t  [0:31];
  longint mx = 0, my = 0, mz = 0;
  longint xs, ys, dx, ang, nx, ny, nz;
  logic   dpos;

  initial begin
    for (int i = 0; i < 32; i++) begin
      real t;
      t = $pow(2.0, -1.0 * i);
      atan_t[i]  = longint'($atan(t) * 4194304.0);
      atanh_t[i] = (i == 0) ? 64'sd0 : longint'(0.5 * $ln((1.0 + t) / (1.0 - t)) * 4194304.0);
      lin_t[i]   = (i <= 22) ? (64'sd1 <<< (22 - i)) : 64'sd0;
    end
  end

  function automatic logic [15:0] rnd16(input longint v);
    longint t;
    t = (v + 64'sd128) >>> 8;
    return t[15:0];
  endfunction

  assign dp_x = rnd16(mx);
  assign dp_y = rnd16(my);
  assign dp_z = rnd16(mz);

  always_comb begin
    xs   = mx >>> int'(dp_idx);
    ys   = my >>> int'(dp_idx);
    dx   = 0;
    ang  = 0;
    dpos = dp_vec ? (my < 0) : (mz >= 0);
    case (dp_coord)
      2'b00:   begin dx = 0;   ang = lin_t[dp_idx];   end
      2'b01:   begin dx = -ys; ang = atan_t[dp_idx];  end
      default: begin dx = ys;  ang = atanh_t[dp_idx]; end
    endcase
    nx = dpos ? mx + dx : mx - dx;
    ny = dpos ? my + xs : my - xs;
    nz = dpos ? mz - ang : mz + ang;
  end

  always @(posedge clk) begin
    if (dp_load) begin
      mx <= longint'($signed(dp_x0)) <<< 8;
      my <= longint'($signed(dp_y0)) <<< 8;
      mz <= longint'($signed(dp_z0)) <<< 8;
    end else if (dp_step) begin
      mx <= nx;
      my <= ny;
      mz <= nz;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [15:0] obs, input logic [15:0] exp, input int tol);
    int d;
    d = int'($signed(obs)) - int'($signed(exp));
    checks++;
    assert (d >= -tol && d <= tol) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h +/-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic check_all_zero(input string pre);
    check({pre, "_cmd_ready"}, cmd_ready, 0);
    check({pre, "_busy"},      busy,      0);
    check({pre, "_dp_load"},   dp_load,   0);
    check({pre, "_dp_step"},   dp_step,   0);
    check({pre, "_dp_idx"},    dp_idx,    0);
    check({pre, "_dp_coord"},  dp_coord,  0);
    check({pre, "_dp_vec"},    dp_vec,    0);
    check({pre, "_dp_x0"},     dp_x0,     0);
    check({pre, "_res_valid"}, res_valid, 0);
    check({pre, "_res_p"},     res_p,     0);
    check({pre, "_res_q"},     res_q,     0);
    check({pre, "_res_func"},  res_func,  0);
  endtask

  // per-command observations
  logic [15:0] ld_x, ld_y, ld_z;
  logic [1:0]  ld_coord;
  logic        ld_vec;
  int          ld_edge, rv_edge, nsteps, edges;
  logic        seen;
  int          idx_log[32];

  // Offer a command and let it be accepted at the next edge
  task automatic issue(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_func = f; cmd_a = a; cmd_b = b;
    check("accept_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_a = 16'h0; cmd_b = 16'h0;
    edges = 1;
  endtask

  // Observe every cycle after the accepting edge until res_valid (bounded)
  task automatic collect();
    nsteps = 0; seen = 1'b0; ld_edge = -1; rv_edge = -1;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (dp_load) begin
        ld_x = dp_x0; ld_y = dp_y0; ld_z = dp_z0;
        ld_coord = dp_coord; ld_vec = dp_vec; ld_edge = edges;
      end
      if (dp_step) begin
        if (nsteps < 32) idx_log[nsteps] = int'(dp_idx);
        nsteps++;
      end
      if (res_valid) begin
        seen = 1'b1; rv_edge = edges;
      end else begin
        @(posedge clk);
        edges++;
      end
    end
    check("res_valid_seen", seen, 1);
    check("steps_issued", nsteps, 16);
  endtask

  task automatic release_res();
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("post_xfer_cmd_ready", cmd_ready, 1);
    check("post_xfer_res_valid", res_valid, 0);
  endtask

  int hyp_exp[16] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p0, q0;
    logic [2:0]  f0;
    int          nst;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_func = 3'd0; cmd_a = 16'h0; cmd_b = 16'h0; res_ready = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    #1;
    check("ready_before_first_edge", cmd_ready, 0);
    @(negedge clk);
    check("ready_after_release", cmd_ready, 1);
    check("idle_busy", busy, 0);

    // mul: 1.0 * 0.5; result visible after the 19th edge counting the accepting one
    issue(3'd0, 16'h4000, 16'h2000);
    collect();
    check("mul_coord", ld_coord, 2'b00);
    check("mul_vec", ld_vec, 0);
    check("mul_x0", ld_x, 16'h4000);
    check("mul_y0", ld_y, 16'h0000);
    check("mul_z0", ld_z, 16'h2000);
    check("mul_load_edge", ld_edge, 1);
    check("mul_res_edge", rv_edge, 19);
    check_near("mul_p", res_p, 16'h2000, 2);
    check("mul_q", res_q, 16'h0000);
    check("mul_func", res_func, 3'd0);
    check("done_busy", busy, 1);
    release_res();

    // cos/sin of 0
    issue(3'd2, 16'h1111, 16'h0000);
    collect();
    check("cos_x0", ld_x, 16'h26DD);
    check("cos_coord", ld_coord, 2'b01);
    check_near("cos_p", res_p, 16'h4000, 4);
    check_near("sin_q", res_q, 16'h0000, 4);
    check("cos_func", res_func, 3'd2);
    release_res();

    // atan(1): operand a must be ignored
    issue(3'd3, 16'hFFFF, 16'h4000);
    collect();
    check("atan_x0", ld_x, 16'h4000);
    check("atan_y0", ld_y, 16'h4000);
    check("atan_z0", ld_z, 16'h0000);
    check("atan_vec", ld_vec, 1);
    check_near("atan_p", res_p, 16'h3244, 4);
    check("atan_q", res_q, 16'h0000);
    release_res();

    // div: -0.5 / 1.0
    issue(3'd1, 16'h4000, 16'hE000);
    collect();
    check("div_y0", ld_y, 16'hE000);
    check("div_mode", {ld_coord, ld_vec}, 3'b001);
    check_near("div_p", res_p, 16'hE000, 2);
    release_res();

    // atan2/mag of (0.5, 0.5): magnitude left uncorrected by the circular gain
    issue(3'd7, 16'h2000, 16'h2000);
    collect();
    check("atan2_x0", ld_x, 16'h2000);
    check("atan2_mode", {ld_coord, ld_vec}, 3'b011);
    check_near("atan2_p", res_p, 16'h3244, 4);
    check_near("atan2_q", res_q, 16'h4A86, 4);
    check("atan2_func", res_func, 3'd7);
    release_res();

    // cosh/sinh of 0 with hyperbolic index schedule
    issue(3'd4, 16'h0000, 16'h0000);
    collect();
    check("cosh_x0", ld_x, 16'h4D48);
    check("cosh_coord", ld_coord, 2'b10);
    for (int i = 0; i < 16; i++) check($sformatf("hyp_idx_%0d", i), idx_log[i], hyp_exp[i]);
    check_near("cosh_p", res_p, 16'h4000, 4);
    check_near("sinh_q", res_q, 16'h0000, 4);
    p0 = res_p; q0 = res_q; f0 = res_func;

    // back-pressure, with a new command already offered
    cmd_valid = 1'b1; cmd_func = 3'd5; cmd_a = 16'h1234; cmd_b = 16'h0000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_res_valid", res_valid, 1);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_busy", busy, 1);
      check("bp_res_p", res_p, p0);
      check("bp_res_q", res_q, q0);
      check("bp_res_func", res_func, f0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("bp_release_cmd_ready", cmd_ready, 1);
    check("bp_release_res_valid", res_valid, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_a = 16'h0;
    edges = 1;
    collect();
    check("exp_x0", ld_x, 16'h4D48);
    check("exp_load_edge", ld_edge, 1);
    check("exp_res_edge", rv_edge, 19);
    check_near("exp_p", res_p, 16'h4000, 4);
    check("exp_q", res_q, 16'h0000);
    check("exp_func", res_func, 3'd5);
    release_res();

    // reset during RUN, at the 7th step
    issue(3'd2, 16'h0000, 16'h1000);
    nst = 0;
    for (int c = 0; c < 30 && nst < 7; c++) begin
      @(negedge clk);
      if (dp_step) nst++;
    end
    check("abort_step_count", nst, 7);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", cmd_ready, 1);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (res_valid || busy) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
